// File: rtl/cpu_datapath_pkg.sv
// Shared CPU definitions used by both the CONTROL sequencer and the datapath.
// Holds the opcode encoding and the default bus widths.
package cpu_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 5;
    localparam int OPC_W      = 3;

    typedef enum logic [OPC_W-1:0] {
        HLT = 3'b000,
        ADD = 3'b001,
        SKZ = 3'b010,
        AND = 3'b011,
        XOR = 3'b100,
        LDA = 3'b101,
        STO = 3'b110,
        JMP = 3'b111
    } opcode_e;

endpackage

// File: rtl/cpu_datapath_if.sv
// Instruction and data memory ports of the CPU core.
// The datapath is the master; the memory or bench is the slave.
interface cpu_datapath_if
    import cpu_pkg::*;
#(
    parameter int DW = DEF_DATA_W,
    parameter int AW = DEF_ADDR_W
) ();

    logic [AW-1:0] ins_addr;
    logic          ins_en;
    logic [DW-1:0] ins_rdata;
    logic [AW-1:0] da_addr;
    logic          da_en;
    logic          da_we;
    logic [DW-1:0] da_wdata;
    logic [DW-1:0] da_rdata;

    modport master (
        output ins_addr, ins_en, da_addr, da_en, da_we, da_wdata,
        input  ins_rdata, da_rdata
    );

    modport slave (
        input  ins_addr, ins_en, da_addr, da_en, da_we, da_wdata,
        output ins_rdata, da_rdata
    );

endinterface

// File: rtl/cpu_datapath_alu.sv
// Combinational accumulator ALU: ADD (carry dropped), AND, XOR.
// Any other opcode passes the accumulator through untouched.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int W = DEF_DATA_W
) (
    input  opcode_e        opcode,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W-1:0]   result
);

    always_comb begin
        result = a;
        case (opcode)
            ADD:     result = a + b;
            AND:     result = a & b;
            XOR:     result = a ^ b;
            default: result = a;
        endcase
    end

endmodule

// File: rtl/cpu_datapath.sv
// CPU datapath: PC, IR, accumulator and memory-data register, driven by
// the strobes of the CONTROL sequencer; talks to synchronous memories.
module cpu_datapath
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_load,
    input  logic              pc_en,
    input  logic              halt,
    input  logic              jmp,
    input  logic              accumulator_load,
    input  logic              accumulator_control,
    input  logic              memIns_en,
    input  logic              memDa_en,
    input  logic              memDa_we,
    output logic [OPC_W-1:0]  opcode,
    output logic              is_zero,
    output logic [ADDR_W-1:0] pc_out,
    cpu_datapath_if.master    mem
);

    if (DATA_W != OPC_W + ADDR_W) begin : g_badWidth
        $error("cpu_datapath: DATA_W must equal 3 + ADDR_W");
    end

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              fetchPend_q, fetchPend_d;
    logic              readPend_q, readPend_d;

    logic              insEn;
    logic              daEn;
    logic              daWe;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] aluResult;
    opcode_e           irOpcode;

    // Memory enables are also masked while reset is held so nothing strobes during reset.
    assign insEn    = memIns_en & ~halt & rst;
    assign daEn     = memDa_en & ~halt & rst;
    assign daWe     = memDa_we & daEn;
    assign operand  = ir_q[ADDR_W-1:0];
    assign irOpcode = opcode_e'(ir_q[DATA_W-1 -: OPC_W]);

    assign mem.ins_addr = pc_q;
    assign mem.ins_en   = insEn;
    assign mem.da_addr  = operand;
    assign mem.da_en    = daEn;
    assign mem.da_we    = daWe;
    assign mem.da_wdata = acc_q;

    assign opcode  = ir_q[DATA_W-1 -: OPC_W];
    assign is_zero = (acc_q == '0);
    assign pc_out  = pc_q;

    cpu_alu #(.W(DATA_W)) u_alu (
        .opcode (irOpcode),
        .a      (acc_q),
        .b      (mdr_q),
        .result (aluResult)
    );

    always_comb begin
        pc_d        = pc_q;
        ir_d        = ir_q;
        acc_d       = acc_q;
        mdr_d       = mdr_q;
        fetchPend_d = insEn;
        readPend_d  = daEn & ~daWe;
        if (!halt) begin
            if (pc_load) begin
                pc_d = jmp ? operand : pc_q + ADDR_W'(2);
            end else if (pc_en) begin
                pc_d = pc_q + ADDR_W'(1);
            end
            if (fetchPend_q) ir_d = mem.ins_rdata;
            if (readPend_q)  mdr_d = mem.da_rdata;
            // The ALU sees the old MDR, so a same-edge capture does not feed this load.
            if (accumulator_load) begin
                acc_d = accumulator_control ? aluResult : mdr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= '0;
            ir_q        <= '0;
            acc_q       <= '0;
            mdr_q       <= '0;
            fetchPend_q <= 1'b0;
            readPend_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            acc_q       <= acc_d;
            mdr_q       <= mdr_d;
            fetchPend_q <= fetchPend_d;
            readPend_q  <= readPend_d;
        end
    end

endmodule

// File: tb/tb_cpu_datapath.sv
// Scoreboard bench for cpu_datapath: expected values are queued as stimulus
// is driven and compared against the DUT at the following sample point.
module tb_cpu_datapath;
    import cpu_pkg::*;

    localparam logic [8:0] S_PCLOAD  = 9'h001;
    localparam logic [8:0] S_PCEN    = 9'h002;
    localparam logic [8:0] S_JMP     = 9'h004;
    localparam logic [8:0] S_ACCLOAD = 9'h008;
    localparam logic [8:0] S_ACCCTRL = 9'h010;
    localparam logic [8:0] S_INSEN   = 9'h020;
    localparam logic [8:0] S_DAEN    = 9'h040;
    localparam logic [8:0] S_DAWE    = 9'h080;
    localparam logic [8:0] S_HALT    = 9'h100;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } sbEntry_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       pc_load, pc_en, halt, jmp;
    logic       accumulator_load, accumulator_control;
    logic       memIns_en, memDa_en, memDa_we;
    logic [2:0] opcode;
    logic       is_zero;
    logic [4:0] pc_out;

    int checks = 0;
    int errors = 0;
    sbEntry_t scoreboard[$];

    cpu_datapath_if memIf ();

    cpu_datapath dut (
        .clk                 (clk),
        .rst                 (rst),
        .pc_load             (pc_load),
        .pc_en               (pc_en),
        .halt                (halt),
        .jmp                 (jmp),
        .accumulator_load    (accumulator_load),
        .accumulator_control (accumulator_control),
        .memIns_en           (memIns_en),
        .memDa_en            (memDa_en),
        .memDa_we            (memDa_we),
        .opcode              (opcode),
        .is_zero             (is_zero),
        .pc_out              (pc_out),
        .mem                 (memIf.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [31:0] observe(input string tag);
        case (tag)
            "pc":       return 32'(pc_out);
            "opcode":   return 32'(opcode);
            "is_zero":  return 32'(is_zero);
            "ins_en":   return 32'(memIf.ins_en);
            "ins_addr": return 32'(memIf.ins_addr);
            "da_en":    return 32'(memIf.da_en);
            "da_we":    return 32'(memIf.da_we);
            "da_addr":  return 32'(memIf.da_addr);
            "da_wdata": return 32'(memIf.da_wdata);
            default:    return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic pushExpect(input string tag, input logic [31:0] value);
        sbEntry_t e;
        e.tag   = tag;
        e.value = value;
        scoreboard.push_back(e);
    endtask

    task automatic drainScoreboard();
        sbEntry_t e;
        #1;
        while (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            checkOutput(e.tag, observe(e.tag), e.value);
        end
    endtask

    task automatic applyStimulus(input logic [8:0] s);
        pc_load             = s[0];
        pc_en               = s[1];
        jmp                 = s[2];
        accumulator_load    = s[3];
        accumulator_control = s[4];
        memIns_en           = s[5];
        memDa_en            = s[6];
        memDa_we            = s[7];
        halt                = s[8];
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetchInstr(input logic [7:0] data);
        applyStimulus(S_INSEN);
        step();
        memIf.ins_rdata = data;
        applyStimulus('0);
        step();
    endtask

    task automatic readData(input logic [7:0] data);
        applyStimulus(S_DAEN);
        step();
        memIf.da_rdata = data;
        applyStimulus('0);
        step();
    endtask

    task automatic loadAcc(input logic useAlu);
        applyStimulus(S_ACCLOAD | (useAlu ? S_ACCCTRL : 9'h000));
        step();
        applyStimulus('0);
    endtask

    task automatic jumpTo(input logic [4:0] addr);
        fetchInstr({3'b111, addr});
        applyStimulus(S_PCLOAD | S_JMP);
        step();
        applyStimulus('0);
    endtask

    initial begin
        rst = 1'b0;
        memIf.ins_rdata = '0;
        memIf.da_rdata  = '0;
        applyStimulus(S_INSEN | S_DAEN | S_DAWE);
        step();
        step();
        pushExpect("pc", 0);
        pushExpect("opcode", 0);
        pushExpect("is_zero", 1);
        pushExpect("ins_en", 0);
        pushExpect("da_en", 0);
        pushExpect("da_we", 0);
        drainScoreboard();
        applyStimulus('0);
        rst = 1'b1;
        step();

        // Build ACC=0x3C, PC=7, open a fetch, then pull reset mid-fetch.
        readData(8'h3C);
        loadAcc(1'b0);
        jumpTo(5'd7);
        pushExpect("pc", 7);
        pushExpect("is_zero", 0);
        pushExpect("da_wdata", 8'h3C);
        drainScoreboard();
        applyStimulus(S_INSEN);
        step();
        memIf.ins_rdata = 8'hA5;
        rst = 1'b0;
        pushExpect("pc", 0);
        pushExpect("opcode", 0);
        pushExpect("is_zero", 1);
        pushExpect("ins_en", 0);
        drainScoreboard();
        applyStimulus('0);
        rst = 1'b1;
        step();
        pushExpect("opcode", 0);
        drainScoreboard();

        jumpTo(5'd3);
        applyStimulus(S_INSEN | S_PCEN);
        pushExpect("ins_en", 1);
        pushExpect("ins_addr", 3);
        drainScoreboard();
        step();
        memIf.ins_rdata = 8'hA5;
        applyStimulus('0);
        pushExpect("pc", 4);
        drainScoreboard();
        step();
        pushExpect("opcode", 3'b101);
        pushExpect("da_addr", 5);
        drainScoreboard();

        readData(8'h0F);
        loadAcc(1'b0);
        pushExpect("da_wdata", 8'h0F);
        pushExpect("is_zero", 0);
        drainScoreboard();
        fetchInstr(8'h20);
        readData(8'hF1);
        loadAcc(1'b1);
        pushExpect("da_wdata", 8'h00);
        pushExpect("is_zero", 1);
        drainScoreboard();

        fetchInstr(8'h80);
        readData(8'h5A);
        loadAcc(1'b1);
        pushExpect("da_wdata", 8'h5A);
        drainScoreboard();
        fetchInstr(8'h60);
        readData(8'h0F);
        loadAcc(1'b1);
        pushExpect("da_wdata", 8'h0A);
        drainScoreboard();
        fetchInstr(8'h40);
        readData(8'hFF);
        loadAcc(1'b1);
        pushExpect("da_wdata", 8'h0A);
        drainScoreboard();

        // Store must not disturb MDR: reloading ACC from MDR afterwards still gives 0x5A.
        readData(8'h5A);
        loadAcc(1'b0);
        fetchInstr(8'hC9);
        applyStimulus(S_DAEN | S_DAWE);
        memIf.da_rdata = 8'h33;
        pushExpect("da_en", 1);
        pushExpect("da_we", 1);
        pushExpect("da_addr", 9);
        pushExpect("da_wdata", 8'h5A);
        drainScoreboard();
        step();
        applyStimulus('0);
        step();
        loadAcc(1'b0);
        pushExpect("da_wdata", 8'h5A);
        drainScoreboard();

        jumpTo(5'd31);
        applyStimulus(S_PCEN);
        step();
        pushExpect("pc", 0);
        drainScoreboard();
        jumpTo(5'd30);
        applyStimulus(S_PCLOAD);
        step();
        pushExpect("pc", 0);
        drainScoreboard();
        jumpTo(5'd31);
        applyStimulus(S_PCLOAD);
        step();
        pushExpect("pc", 1);
        drainScoreboard();
        fetchInstr(8'h12);
        applyStimulus(S_PCLOAD | S_JMP | S_PCEN);
        step();
        pushExpect("pc", 8'h12);
        drainScoreboard();
        applyStimulus(S_PCEN);
        step();
        pushExpect("pc", 8'h13);
        drainScoreboard();

        // A fetch left pending when halt rises must be dropped, not deferred.
        applyStimulus(S_INSEN);
        step();
        memIf.ins_rdata = 8'hFF;
        memIf.da_rdata  = 8'hFF;
        applyStimulus(9'h1FF);
        for (int i = 0; i < 5; i++) begin
            pushExpect("ins_en", 0);
            pushExpect("da_en", 0);
            pushExpect("da_we", 0);
            pushExpect("pc", 8'h13);
            pushExpect("opcode", 0);
            pushExpect("da_addr", 8'h12);
            pushExpect("da_wdata", 8'h5A);
            drainScoreboard();
            step();
        end
        applyStimulus('0);
        step();
        pushExpect("opcode", 0);
        pushExpect("pc", 8'h13);
        pushExpect("da_wdata", 8'h5A);
        drainScoreboard();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
Datapath responder for the CONTROL sequencer. It consumes CONTROL's strobes (pc_load, pc_en, halt, jmp, accumulator_load, accumulator_control, memIns_en, memDa_en, memDa_we) and returns opcode and is_zero. It holds the PC, the instruction register (IR), the accumulator and the memory-data register. It drives the synchronous instruction and data memory ports. CONTROL plus cpu_datapath form the complete CPU core.

Parameters:
DATA_W, 8, data/accumulator/instruction width
ADDR_W, 5, PC and operand-address width; instruction = {opcode[2:0], addr[ADDR_W-1:0]}, DATA_W = 3 + ADDR_W (elaboration assertion)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
pc_load  input  1  PC load strobe from CONTROL
pc_en  input  1  PC increment strobe
halt  input  1  freeze all datapath state
jmp  input  1  qualifies pc_load as jump
accumulator_load  input  1  accumulator write strobe
accumulator_control  input  1  accumulator source: 1 = ALU result, 0 = memory data
memIns_en  input  1  instruction fetch request
memDa_en  input  1  data memory access request
memDa_we  input  1  data memory write (with memDa_en)
opcode  output  3  IR[DATA_W-1:DATA_W-3]
is_zero  output  1  accumulator == 0
ins_addr  output  ADDR_W  instruction memory address (= PC)
ins_en  output  1  instruction memory read enable
ins_rdata  input  DATA_W  instruction memory data, valid 1 cycle after ins_en
da_addr  output  ADDR_W  data address (= IR operand field)
da_en  output  1  data memory enable
da_we  output  1  data memory write enable
da_wdata  output  DATA_W  write data (= accumulator)
da_rdata  input  DATA_W  read data, valid 1 cycle after a read
pc_out  output  ADDR_W  current PC (debug)

Behaviour:
- Reset (rst=0, async):
  - PC=0, IR=0 (opcode=000=HLT), ACC=0, MDR=0, is_zero=1.
  - ins_en, da_en and da_we are 0; internal read-pending flags are cleared.
- halt=1 overrides every other strobe:
  - no update to PC, IR, ACC or MDR;
  - ins_en, da_en and da_we are forced to 0;
  - pending captures are dropped.
- PC update, priority pc_load > pc_en:
  - pc_load & jmp: PC <= IR operand;
  - pc_load & !jmp: PC <= PC+2 (SKZ skip, CONTROL gates it with is_zero);
  - pc_en: PC <= PC+1.
  - Arithmetic is modulo 2^ADDR_W; 31+1 wraps to 0, 31+2 to 1.
- Fetch:
  - ins_en = memIns_en & !halt, combinational; ins_addr = PC.
  - A one-cycle pending flag is set. On the next edge IR <= ins_rdata.
  - If pc_en is asserted in the fetch cycle, the fetch still uses the pre-increment PC.
- Data access:
  - da_en = memDa_en & !halt; da_we = memDa_we & da_en.
  - da_addr = IR operand; da_wdata = ACC.
  - A read (da_en & !da_we) sets a pending flag; on the next edge MDR <= da_rdata.
  - Writes set no flag.
- Accumulator (on accumulator_load & !halt):
  - accumulator_control=0: ACC <= MDR (LDA).
  - accumulator_control=1: ACC <= ALU(opcode, ACC, MDR): ADD = sum truncated to DATA_W (carry discarded), AND = bitwise, XOR = bitwise; any other opcode = ACC unchanged.
  - If an accumulator load and an MDR capture hit the same edge, the load uses the old MDR. CONTROL must place the load at least 1 cycle after the read data returns.
- is_zero is combinational from the ACC register only.
- opcode is combinational from the IR register; it changes the cycle after the fetch data is captured.
- Reset mid-fetch or mid-access: pending flag cleared, no capture occurs after reset release.

Decomposition:
- Shared package cpu_pkg, also used by CONTROL: opcode enum HLT=000, ADD=001, SKZ=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111; DATA_W/ADDR_W defaults.
- One sub-module: cpu_alu, combinational; inputs opcode, a, b; output result.

Test Plan:
- Reset: rst=0 mid-operation with ACC=0x3C, PC=7 → immediately PC=0, opcode=000, is_zero=1, ins_en=0.
- Fetch: PC=3, memIns_en pulse, ins_rdata=8'hA5 next cycle → IR=A5, opcode=101, da_addr=5.
- LDA then ADD:
  - LDA: da_rdata=0x0F, load with control=0 → ACC=0x0F, is_zero=0.
  - ADD: IR opcode 001, MDR=0xF1, load with control=1 → ACC=0x00, is_zero=1.
- STO: ACC=0x5A, IR=110_01001, memDa_en=memDa_we=1 → da_we=1, da_addr=9, da_wdata=5A, MDR unchanged.
- PC control:
  - PC=31, pc_en → PC=0.
  - PC=30, pc_load & !jmp → PC=0.
  - IR operand 0x12, pc_load & jmp & pc_en same cycle → PC=0x12.
- Halt: halt=1 with all strobes high for 5 cycles → PC/IR/ACC constant, ins_en=da_en=da_we=0.
